ahb_slave_mem: RTL and testbench

- AHB-Lite responder backing the bus master: word-addressed SRAM model with programmable wait states and two-cycle ERROR responses.
- Sits on the far side of the bus from the master. Consumes the master's address/control/HWDATA; returns HRDATA/HREADYOUT/HRESP.
- In a single-slave system, HREADYOUT is looped straight back as HREADY.

---
 rtl/util.sv | 18 +
 rtl/ahb_slave_decode.sv | 34 +++
 rtl/ahb_slave_mem.sv | 157 +++++++++++++++
 tb/tb_ahb_slave_mem.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/util.sv
// Shared AHB-Lite encodings: transfer type, response and transfer size.
package util;
  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } trans_t;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } resp_t;

  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;
endpackage

// File: rtl/ahb_slave_decode.sv
// Combinational address check for the SRAM responder: window hit, size alignment
// and word index (offset from BASE_ADDR, modulo DEPTH).
module ahb_slave_decode
  import util::*;
#(
  parameter int              WIDTH     = 32,
  parameter int              DEPTH     = 256,
  parameter logic [WIDTH-1:0] BASE_ADDR = '0,
  localparam int             IDX_W     = $clog2(DEPTH)
) (
  input  logic [WIDTH-1:0] addr,
  input  logic [2:0]       size,
  output logic             in_range,
  output logic             aligned,
  output logic [IDX_W-1:0] word_index
);
  // One extra bit so the window span cannot wrap for large DEPTH.
  localparam logic [WIDTH:0] SPAN = (WIDTH+1)'(4 * DEPTH);

  logic [WIDTH-1:0] offset;

  assign offset     = addr - BASE_ADDR;
  assign in_range   = (addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign word_index = offset[IDX_W+1:2];

  always_comb begin
    case (size)
      SIZE_BYTE: aligned = 1'b1;
      SIZE_HALF: aligned = ~addr[0];
      SIZE_WORD: aligned = (addr[1:0] == 2'b00);
      default:   aligned = 1'b0;
    endcase
  end
endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite SRAM responder: WAIT_STATES low cycles per OKAY data phase, two-cycle ERROR.
// Define AHB_SLAVE_BYTE_LANES_EN to accept byte/halfword transfers with lane-masked writes.
module ahb_slave_mem
  import util::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               DEPTH       = 256,
  parameter logic [WIDTH-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int               WAIT_STATES = 1
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             HSEL,
  input  logic [WIDTH-1:0] HADDR,
  input  logic             HWRITE,
  input  logic [2:0]       HSIZE,
  input  logic [2:0]       HBURST,
  input  logic [3:0]       HPROT,
  input  trans_t           HTRANS,
  input  logic             HMASTLOCK,
  input  logic             HREADY,
  input  logic [WIDTH-1:0] HWDATA,
  output logic [WIDTH-1:0] HRDATA,
  output logic             HREADYOUT,
  output logic             HRESP
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} slv_state_t;

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  logic [WIDTH-1:0] mem [DEPTH];

  slv_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] addr_q;
  logic             write_q;
  logic             ready, take, accept, req_err, size_ok;
  resp_t            resp;
  logic             in_range, aligned;
  logic [IDX_W-1:0] word_index;
  logic             unused_inputs;

  assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK};

  ahb_slave_decode #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .BASE_ADDR(BASE_ADDR)
  ) u_decode (
    .addr      (HADDR),
    .size      (HSIZE),
    .in_range  (in_range),
    .aligned   (aligned),
    .word_index(word_index)
  );

`ifdef AHB_SLAVE_BYTE_LANES_EN
  logic [2:0]       size_q;
  logic [1:0]       lane_q;
  logic [3:0]       be;
  logic [WIDTH-1:0] lane_mask;

  assign size_ok = (HSIZE <= SIZE_WORD);

  always_comb begin
    case (size_q)
      SIZE_BYTE: be = 4'b0001 << lane_q;
      SIZE_HALF: be = 4'b0011 << lane_q;
      default:   be = 4'b1111;
    endcase
    for (int i = 0; i < WIDTH; i++) lane_mask[i] = be[(i / 8) % 4];
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      size_q <= '0;
      lane_q <= '0;
    end else if (take) begin
      size_q <= HSIZE;
      lane_q <= HADDR[1:0];
    end
  end
`else
  assign size_ok = (HSIZE == SIZE_WORD);
`endif

  assign accept  = HSEL & HREADY & (HTRANS == TRANS_NONSEQ || HTRANS == TRANS_SEQ);
  assign req_err = ~in_range | ~aligned | ~size_ok;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = 1'b1;
    resp      = RESP_OKAY;
    take      = 1'b0;
    case (state)
      S_WAIT: begin
        ready = 1'b0;
        if (cnt == '0) state_nxt = S_DATA;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      S_ERR1: begin
        ready     = 1'b0;
        resp      = RESP_ERROR;
        state_nxt = S_ERR2;
      end
      // Ready states: the current data phase closes here and the next one may open.
      S_IDLE, S_DATA, S_ERR2: begin
        if (state == S_ERR2) resp = RESP_ERROR;
        take = accept;
        if (!accept) begin
          state_nxt = S_IDLE;
        end else if (req_err) begin
          state_nxt = S_ERR1;
        end else if (WAIT_STATES > 0) begin
          state_nxt = S_WAIT;
          cnt_nxt   = CNT_LOAD;
        end else begin
          state_nxt = S_DATA;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (take) begin
        addr_q  <= word_index;
        write_q <= HWRITE;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESET && state == S_DATA && write_q) begin
`ifdef AHB_SLAVE_BYTE_LANES_EN
      mem[addr_q] <= (mem[addr_q] & ~lane_mask) | (HWDATA & lane_mask);
`else
      mem[addr_q] <= HWDATA;
`endif
    end
  end

  assign HRDATA    = (state == S_DATA && !write_q) ? mem[addr_q] : '0;
  assign HREADYOUT = ready;
  assign HRESP     = resp;
endmodule

// File: tb/tb_ahb_slave_mem.sv
// Two responders (2 wait states at base 0, zero wait at base 0x100) driven by a
// transaction-level master and checked each cycle against a per-transfer model.
`timescale 1ns/1ps
module tb_ahb_slave_mem;
  import util::*;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_0100;
  localparam int          WS0   = 2;
  localparam int          WS1   = 0;

  typedef struct packed {
    logic        sel;
    trans_t      trans;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } item_t;

  typedef struct packed {
    logic        rdy;
    logic        resp;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        hreset[2], hsel[2], hwrite[2], hready[2], hreadyout[2], hresp[2];
  logic [31:0] haddr[2], hwdata[2], hrdata[2];
  logic [2:0]  hsize[2];
  trans_t      htrans[2];
  logic [2:0]  hburst    = 3'd0;
  logic [3:0]  hprot     = 4'd3;
  logic        hmastlock = 1'b0;

  ahb_slave_mem #(.WIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(BASE0), .WAIT_STATES(WS0)) dut0 (
    .HCLK(clk), .HRESET(hreset[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HWRITE(hwrite[0]),
    .HSIZE(hsize[0]), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans[0]), .HMASTLOCK(hmastlock),
    .HREADY(hready[0]), .HWDATA(hwdata[0]), .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]),
    .HRESP(hresp[0]));

  ahb_slave_mem #(.WIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(BASE1), .WAIT_STATES(WS1)) dut1 (
    .HCLK(clk), .HRESET(hreset[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HWRITE(hwrite[1]),
    .HSIZE(hsize[1]), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans[1]), .HMASTLOCK(hmastlock),
    .HREADY(hready[1]), .HWDATA(hwdata[1]), .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]),
    .HRESP(hresp[1]));

  int vectors = 0, miscompares = 0;
  bit armed = 0;

  item_t       plan[2][$];
  exp_t        eq[2][$];
  exp_t        cur[2];
  item_t       ap[2];
  bit          from_plan[2], rst_req[2], rst_now[2], pw_vld[2];
  int          pw_idx[2];
  logic [31:0] pw_mask[2], hw_cur[2];
  logic [31:0] mm[2][DEPTH];

  function automatic item_t mk(logic s, trans_t t, logic w, logic [31:0] a, logic [2:0] z, logic [31:0] d);
    item_t it;
    it.sel = s; it.trans = t; it.wr = w; it.addr = a; it.size = z; it.wdata = d;
    return it;
  endfunction

  function automatic exp_t mx(logic r, logic s, logic [31:0] d);
    exp_t e;
    e.rdy = r; e.resp = s; e.rdata = d;
    return e;
  endfunction

  function automatic logic [31:0] base_of(int u);
    return (u == 0) ? BASE0 : BASE1;
  endfunction

  function automatic bit is_err(int u, item_t it);
    longint off = longint'(it.addr) - longint'(base_of(u));
    if (off < 0 || off >= 4 * DEPTH) return 1;
    if (it.size > 3'd2) return 1;
`ifndef AHB_SLAVE_BYTE_LANES_EN
    if (it.size != 3'd2) return 1;
`endif
    if ((it.addr % (32'd1 << it.size)) != 0) return 1;
    return 0;
  endfunction

  // Expected outputs for every cycle of the data phase that this address phase opens.
  task automatic accept(int u, item_t it);
    int idx;
    int ws = (u == 0) ? WS0 : WS1;
    hw_cur[u] = $urandom;
    if (!(it.sel && (it.trans == TRANS_NONSEQ || it.trans == TRANS_SEQ))) begin
      eq[u].push_back(mx(1, 0, 0));
    end else if (is_err(u, it)) begin
      eq[u].push_back(mx(0, 1, 0));
      eq[u].push_back(mx(1, 1, 0));
    end else begin
      idx = int'((it.addr - base_of(u)) >> 2) % DEPTH;
      for (int i = 0; i < ws; i++) eq[u].push_back(mx(0, 0, 0));
      if (it.wr) begin
        pw_vld[u] = 1;
        pw_idx[u] = idx;
        case (it.size)
          3'd0:    pw_mask[u] = 32'hFF << (8 * it.addr[1:0]);
          3'd1:    pw_mask[u] = 32'hFFFF << (8 * it.addr[1:0]);
          default: pw_mask[u] = 32'hFFFF_FFFF;
        endcase
        hw_cur[u] = it.wdata;
        eq[u].push_back(mx(1, 0, 0));
      end else begin
        eq[u].push_back(mx(1, 0, mm[u][idx]));
      end
    end
  endtask

  task automatic edge_model(int u);
    if (rst_now[u]) begin
      eq[u].delete();
      pw_vld[u] = 0;
      cur[u] = mx(1, 0, 0);
    end else begin
      if (cur[u].rdy) begin
        if (pw_vld[u]) begin
          mm[u][pw_idx[u]] = (mm[u][pw_idx[u]] & ~pw_mask[u]) | (hwdata[u] & pw_mask[u]);
          pw_vld[u] = 0;
        end
        accept(u, ap[u]);
        if (from_plan[u]) void'(plan[u].pop_front());
      end
      if (eq[u].size() == 0) eq[u].push_back(mx(1, 0, 0));
      cur[u] = eq[u].pop_front();
    end
  endtask

  task automatic drive(int u);
    rst_now[u] = rst_req[u];
    rst_req[u] = 0;
    from_plan[u] = !rst_now[u] && plan[u].size() > 0;
    ap[u] = from_plan[u] ? plan[u][0] : mk(0, TRANS_IDLE, 0, 0, 3'd2, 0);
    hreset[u] = rst_now[u];
    hsel[u]   = ap[u].sel;
    htrans[u] = ap[u].trans;
    hwrite[u] = ap[u].wr;
    haddr[u]  = ap[u].addr;
    hsize[u]  = ap[u].size;
    hready[u] = cur[u].rdy;
    hwdata[u] = hw_cur[u];
  endtask

  task automatic step();
    @(posedge clk);
    for (int u = 0; u < 2; u++) edge_model(u);
    #1;
    for (int u = 0; u < 2; u++) drive(u);
  endtask

  always @(negedge clk) begin
    if (armed) begin
      for (int u = 0; u < 2; u++) begin
        vectors++;
        if ({hreadyout[u], hresp[u], hrdata[u]} !== {cur[u].rdy, cur[u].resp, cur[u].rdata}) begin
          miscompares++;
          $display("FAIL cycle u%0d t=%0t: got rdy=%b resp=%b rdata=%h, want rdy=%b resp=%b rdata=%h",
                   u, $time, hreadyout[u], hresp[u], hrdata[u], cur[u].rdy, cur[u].resp, cur[u].rdata);
        end
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Runs until all queued transfers are done; tallies the model's view of unit u.
  task automatic run_plan(int u, output int n_low, output int n_err, output logic [31:0] last_rd);
    int guard = 0;
    n_low = 0; n_err = 0; last_rd = 0;
    while ((plan[0].size() + plan[1].size() + eq[0].size() + eq[1].size()) > 0 && guard < 20000) begin
      step();
      guard++;
      if (!cur[u].rdy) n_low++;
      if (cur[u].resp) n_err++;
      if (cur[u].rdy && cur[u].rdata != 0) last_rd = cur[u].rdata;
    end
    if (guard >= 20000) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d cycles, want under 20000", guard);
    end
  endtask

  function automatic item_t rnd_item(int u);
    item_t it;
    int k = $urandom_range(0, 99);
    int z = $urandom_range(0, 9);
    int a = $urandom_range(0, 9);
    it.sel   = ($urandom_range(0, 9) != 0);
    it.trans = (k < 10) ? TRANS_IDLE : (k < 15) ? TRANS_BUSY : (k < 60) ? TRANS_NONSEQ : TRANS_SEQ;
    it.wr    = $urandom_range(0, 1);
    it.size  = (z < 6) ? 3'd2 : (z < 8) ? 3'd0 : (z < 9) ? 3'd1 : 3'($urandom_range(3, 7));
    if (a < 8)       it.addr = base_of(u) + $urandom_range(0, 4 * DEPTH - 1);
    else if (a == 8) it.addr = base_of(u) + 4 * DEPTH + $urandom_range(0, 15);
    else             it.addr = base_of(u) - $urandom_range(1, 8);
    if (a < 5) it.addr[1:0] = 2'b00;
    it.wdata = $urandom;
    return it;
  endfunction

  int          nl, ne;
  logic [31:0] lr;

  initial begin
    for (int u = 0; u < 2; u++) begin
      cur[u] = mx(1, 0, 0);
      hw_cur[u] = 0;
      rst_req[u] = 1;
      drive(u);
    end
    rst_req[0] = 1; rst_req[1] = 1;
    step();
    armed = 1;
    step();
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("reset_hreadyout_u%0d", u), 32'(hreadyout[u]), 32'd1);
      chk($sformatf("reset_hresp_u%0d", u), 32'(hresp[u]), 32'd0);
      chk($sformatf("reset_hrdata_u%0d", u), hrdata[u], 32'd0);
    end

    for (int i = 0; i < DEPTH; i++)
      for (int u = 0; u < 2; u++)
        plan[u].push_back(mk(1, (i % 2) ? TRANS_SEQ : TRANS_NONSEQ, 1, base_of(u) + 4 * i, 3'd2, $urandom));
    run_plan(0, nl, ne, lr);

    plan[0].push_back(mk(1, TRANS_NONSEQ, 1, 32'h10, 3'd2, 32'hDEADBEEF));
    plan[0].push_back(mk(1, TRANS_NONSEQ, 0, 32'h10, 3'd2, 32'h0));
    run_plan(0, nl, ne, lr);
    chk("ws2_low_cycles", 32'(nl), 32'd4);
    chk("ws2_rdata", lr, 32'hDEADBEEF);
    chk("ws2_err_cycles", 32'(ne), 32'd0);

    plan[1].push_back(mk(1, TRANS_NONSEQ, 1, BASE1 + 32'h20, 3'd2, 32'h12345678));
    plan[1].push_back(mk(1, TRANS_NONSEQ, 0, BASE1 + 32'h20, 3'd2, 32'h0));
    run_plan(1, nl, ne, lr);
    chk("ws0_low_cycles", 32'(nl), 32'd0);
    chk("ws0_rdata", lr, 32'h12345678);

    plan[0].push_back(mk(1, TRANS_NONSEQ, 0, 32'h400, 3'd2, 32'h0));
    run_plan(0, nl, ne, lr);
    chk("oor_low_cycles", 32'(nl), 32'd1);
    chk("oor_err_cycles", 32'(ne), 32'd2);

    plan[1].push_back(mk(1, TRANS_NONSEQ, 0, BASE1 + 32'h400, 3'd2, 32'h0));
    plan[1].push_back(mk(1, TRANS_NONSEQ, 0, BASE1 - 32'h4, 3'd2, 32'h0));
    run_plan(1, nl, ne, lr);
    chk("base_bounds_err_cycles", 32'(ne), 32'd4);

    plan[0].push_back(mk(1, TRANS_NONSEQ, 1, 32'h20, 3'd2, 32'h11223344));
    plan[0].push_back(mk(1, TRANS_NONSEQ, 1, 32'h22, 3'd2, 32'hFFFFFFFF));
    plan[0].push_back(mk(1, TRANS_NONSEQ, 0, 32'h20, 3'd2, 32'h0));
    run_plan(0, nl, ne, lr);
    chk("misalign_err_cycles", 32'(ne), 32'd2);
    chk("misalign_low_cycles", 32'(nl), 32'd5);
    chk("misalign_mem_kept", lr, 32'h11223344);

    plan[0].push_back(mk(1, TRANS_BUSY, 1, 32'h10, 3'd2, 32'h0));
    plan[0].push_back(mk(1, TRANS_IDLE, 1, 32'h10, 3'd2, 32'h0));
    run_plan(0, nl, ne, lr);
    chk("busy_idle_low", 32'(nl), 32'd0);
    chk("busy_idle_err", 32'(ne), 32'd0);

    plan[0].push_back(mk(1, TRANS_NONSEQ, 1, 32'h30, 3'd2, 32'hCAFE0001));
    run_plan(0, nl, ne, lr);
    plan[0].push_back(mk(1, TRANS_NONSEQ, 1, 32'h30, 3'd2, 32'h55555555));
    for (int g = 0; g < 10 && cur[0].rdy; g++) step();
    chk("rst_in_wait", 32'(hreadyout[0]), 32'd0);
    rst_req[0] = 1;
    step();
    step();
    chk("rst_abort_hreadyout", 32'(hreadyout[0]), 32'd1);
    chk("rst_abort_hresp", 32'(hresp[0]), 32'd0);
    chk("rst_abort_hrdata", hrdata[0], 32'd0);
    plan[0].push_back(mk(1, TRANS_NONSEQ, 0, 32'h30, 3'd2, 32'h0));
    run_plan(0, nl, ne, lr);
    chk("rst_write_dropped", lr, 32'hCAFE0001);

    plan[0].push_back(mk(1, TRANS_NONSEQ, 1, 32'h31, 3'd0, 32'hABABABAB));
    plan[0].push_back(mk(1, TRANS_NONSEQ, 0, 32'h30, 3'd2, 32'h0));
    run_plan(0, nl, ne, lr);
`ifdef AHB_SLAVE_BYTE_LANES_EN
    chk("byte_write_err", 32'(ne), 32'd0);
    chk("byte_write_lane1", lr, 32'hCAFEAB01);
`else
    chk("byte_write_err", 32'(ne), 32'd2);
    chk("byte_write_kept", lr, 32'hCAFE0001);
`endif

    for (int i = 0; i < 600; i++)
      for (int u = 0; u < 2; u++) plan[u].push_back(rnd_item(u));
    run_plan(0, nl, ne, lr);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
